// File: rtl/axi4_wr_arbiter.sv
// Two-master AXI4 write-channel arbiter, round-robin at transaction granularity.
// Latency: grant registered in IDLE (1 cycle); AW/W/B pass-through is combinational, zero per-beat latency.
// Backpressure: slave ready/valid routed straight to/from the owning master; the waiting master sees ready=0.
//
// Ports:
//   ACLK, ARESETn            clock, asynchronous active-low reset
//   m_AW*/m_W*/m_B*          two master-side write ports, slice i belongs to master i
//   s_AW*/s_W*/s_B*          single slave-side write port
//   grant                    one-hot current owner (0 while idle)
//   wlast_err                pulses on a W handshake whose m_WLAST disagrees with the beat count
module axi4_wr_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  input  logic [2*ADDR_WIDTH-1:0] m_AWADDR,
  input  logic [15:0]             m_AWLEN,
  input  logic [1:0]              m_AWVALID,
  output logic [1:0]              m_AWREADY,
  input  logic [2*DATA_WIDTH-1:0] m_WDATA,
  input  logic [1:0]              m_WVALID,
  input  logic [1:0]              m_WLAST,
  output logic [1:0]              m_WREADY,
  output logic [3:0]              m_BRESP,
  output logic [1:0]              m_BVALID,
  input  logic [1:0]              m_BREADY,
  output logic [ADDR_WIDTH-1:0]   s_AWADDR,
  output logic [7:0]              s_AWLEN,
  output logic                    s_AWVALID,
  input  logic                    s_AWREADY,
  output logic [DATA_WIDTH-1:0]   s_WDATA,
  output logic                    s_WVALID,
  output logic                    s_WLAST,
  input  logic                    s_WREADY,
  input  logic [1:0]              s_BRESP,
  input  logic                    s_BVALID,
  output logic                    s_BREADY,
  output logic [1:0]              grant,
  output logic                    wlast_err
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t     state_q, state_d;
  logic       g_q;
  logic       last_g_q;
  logic [7:0] len_q;
  logic [7:0] beat_q;

  // Fields of the currently granted master.
  logic [ADDR_WIDTH-1:0] sel_awaddr;
  logic [7:0]            sel_awlen;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  sel_awvalid, sel_wvalid, sel_wlast, sel_bready;

  assign sel_awaddr  = g_q ? m_AWADDR[ADDR_WIDTH +: ADDR_WIDTH] : m_AWADDR[0 +: ADDR_WIDTH];
  assign sel_awlen   = g_q ? m_AWLEN[8 +: 8] : m_AWLEN[0 +: 8];
  assign sel_wdata   = g_q ? m_WDATA[DATA_WIDTH +: DATA_WIDTH] : m_WDATA[0 +: DATA_WIDTH];
  assign sel_awvalid = m_AWVALID[g_q];
  assign sel_wvalid  = m_WVALID[g_q];
  assign sel_wlast   = m_WLAST[g_q];
  assign sel_bready  = m_BREADY[g_q];

  logic aw_hs, w_hs, b_hs, last_beat, pick;

  assign aw_hs     = (state_q == ADDR) && sel_awvalid && s_AWREADY;
  assign w_hs      = (state_q == DATA) && sel_wvalid && s_WREADY;
  assign b_hs      = (state_q == RESP) && s_BVALID && sel_bready;
  assign last_beat = (beat_q == len_q);
  // Tie goes to the master that did not finish the previous transaction.
  assign pick      = (&m_AWVALID) ? ~last_g_q : m_AWVALID[1];

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      g_q      <= 1'b0;
      last_g_q <= 1'b1;
      len_q    <= 8'd0;
      beat_q   <= 8'd0;
    end else begin
      if (state_q == IDLE && |m_AWVALID) g_q <= pick;
      if (aw_hs) begin
        len_q  <= sel_awlen;
        beat_q <= 8'd0;
      end
      // Wraps 255 -> 0 only on the terminal beat of a 256-beat burst, when it no longer matters.
      if (w_hs) beat_q <= beat_q + 8'd1;
      if (b_hs) last_g_q <= g_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    m_AWREADY = 2'b00;
    m_WREADY  = 2'b00;
    m_BVALID  = 2'b00;
    m_BRESP   = 4'b0000;
    s_AWADDR  = '0;
    s_AWLEN   = 8'd0;
    s_AWVALID = 1'b0;
    s_WDATA   = '0;
    s_WVALID  = 1'b0;
    s_WLAST   = 1'b0;
    s_BREADY  = 1'b0;
    grant     = 2'b00;
    wlast_err = 1'b0;

    if (state_q != IDLE) grant = g_q ? 2'b10 : 2'b01;

    case (state_q)
      IDLE: begin
        if (|m_AWVALID) state_d = ADDR;
      end
      ADDR: begin
        s_AWADDR       = sel_awaddr;
        s_AWLEN        = sel_awlen;
        s_AWVALID      = sel_awvalid;
        m_AWREADY[g_q] = s_AWREADY;
        if (aw_hs) state_d = DATA;
      end
      DATA: begin
        s_WDATA       = sel_wdata;
        s_WVALID      = sel_wvalid;
        // Burst end is taken from the beat count, never from the master's WLAST.
        s_WLAST       = last_beat;
        m_WREADY[g_q] = s_WREADY;
        wlast_err     = w_hs && (sel_wlast != last_beat);
        if (w_hs && last_beat) state_d = RESP;
      end
      RESP: begin
        s_BREADY      = sel_bready;
        m_BVALID[g_q] = s_BVALID;
        m_BRESP       = g_q ? {s_BRESP, 2'b00} : {2'b00, s_BRESP};
        if (b_hs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi4_wr_arbiter.sv
// Self-checking bench for axi4_wr_arbiter: directed scenarios plus randomized traffic,
// compared every cycle against a transaction-level model of owner / address / beat progress.
// Inputs driven on the falling edge, outputs sampled 1 time unit later.
module tb_axi4_wr_arbiter;
  localparam int DW = 32;
  localparam int AW = 16;

  logic            ACLK = 1'b0;
  logic            ARESETn = 1'b0;
  logic [2*AW-1:0] m_AWADDR = '0;
  logic [15:0]     m_AWLEN = '0;
  logic [1:0]      m_AWVALID = '0;
  logic [1:0]      m_AWREADY;
  logic [2*DW-1:0] m_WDATA = '0;
  logic [1:0]      m_WVALID = '0;
  logic [1:0]      m_WLAST = '0;
  logic [1:0]      m_WREADY;
  logic [3:0]      m_BRESP;
  logic [1:0]      m_BVALID;
  logic [1:0]      m_BREADY = '0;
  logic [AW-1:0]   s_AWADDR;
  logic [7:0]      s_AWLEN;
  logic            s_AWVALID;
  logic            s_AWREADY = 1'b0;
  logic [DW-1:0]   s_WDATA;
  logic            s_WVALID;
  logic            s_WLAST;
  logic            s_WREADY = 1'b0;
  logic [1:0]      s_BRESP = '0;
  logic            s_BVALID = 1'b0;
  logic            s_BREADY;
  logic [1:0]      grant;
  logic            wlast_err;

  axi4_wr_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .m_AWADDR(m_AWADDR), .m_AWLEN(m_AWLEN), .m_AWVALID(m_AWVALID), .m_AWREADY(m_AWREADY),
    .m_WDATA(m_WDATA), .m_WVALID(m_WVALID), .m_WLAST(m_WLAST), .m_WREADY(m_WREADY),
    .m_BRESP(m_BRESP), .m_BVALID(m_BVALID), .m_BREADY(m_BREADY),
    .s_AWADDR(s_AWADDR), .s_AWLEN(s_AWLEN), .s_AWVALID(s_AWVALID), .s_AWREADY(s_AWREADY),
    .s_WDATA(s_WDATA), .s_WVALID(s_WVALID), .s_WLAST(s_WLAST), .s_WREADY(s_WREADY),
    .s_BRESP(s_BRESP), .s_BVALID(s_BVALID), .s_BREADY(s_BREADY),
    .grant(grant), .wlast_err(wlast_err)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [AW-1:0] addr;
    logic [7:0]    len;
    bit            bad;
    int            id;
  } txn_t;

  txn_t q0[$];
  txn_t q1[$];
  txn_t cur;
  int   gseq[$];

  int n_checks = 0;
  int n_err    = 0;

  // Model: who owns the slave and how far their transaction has progressed.
  int own      = -1;
  int last_own = 1;
  bit aw_taken = 1'b0;
  int beats    = 0;
  int next_id  = 1;

  int p_mv = 100, p_ar = 100, p_wv = 100, p_wr = 100, p_bv = 100, p_br = 100;
  int br_hold = 0;
  bit wr_toggle = 1'b0;
  bit toggle_ph = 1'b0;

  int          obs_beats, obs_err, exp_err;
  logic [31:0] obs_xor, exp_xor;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  function automatic bit roll(input int p);
    return $urandom_range(99) < p;
  endfunction

  function automatic logic [31:0] mk_data(input int id, input int b);
    return {id[15:0] ^ 16'hA5A5, b[15:0]};
  endfunction

  function automatic bit has(input int m);
    return (m == 0) ? (q0.size() > 0) : (q1.size() > 0);
  endfunction

  function automatic txn_t head(input int m);
    return (m == 0) ? q0[0] : q1[0];
  endfunction

  task automatic push(input int m, input logic [AW-1:0] a, input logic [7:0] l, input bit bad);
    txn_t t;
    t.addr = a; t.len = l; t.bad = bad; t.id = next_id;
    next_id++;
    if (m == 0) q0.push_back(t);
    else        q1.push_back(t);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, {m_AWREADY, m_WREADY, m_BVALID, s_AWVALID, s_WVALID, s_BREADY, grant, wlast_err}, 64'd0);
    chk({tag, "_aw"}, {s_AWADDR, s_AWLEN}, 64'd0);
    chk({tag, "_w"}, {s_WDATA, s_WLAST}, 64'd0);
    chk({tag, "_b"}, {60'd0, m_BRESP}, 64'd0);
  endtask

  task automatic step();
    logic [1:0]    mav, wv, wl, br;
    logic [AW-1:0] ad [2];
    logic [7:0]    ln [2];
    logic [DW-1:0] wd [2];
    logic [1:0]    e_awrdy, e_wrdy, e_bvalid, e_grant;
    logic [3:0]    e_bresp;
    logic [23:0]   e_aw;
    logic [32:0]   e_sw;
    logic          e_sawv, e_swv, e_sbr, e_err;
    bit            in_addr, in_data, in_resp, lastb;
    txn_t          t;

    @(negedge ACLK);
    in_addr = (own >= 0) && !aw_taken;
    in_data = (own >= 0) && aw_taken && (beats <= int'(cur.len));
    in_resp = (own >= 0) && aw_taken && (beats > int'(cur.len));
    lastb   = in_data && (beats == int'(cur.len));

    for (int i = 0; i < 2; i++) begin
      if (has(i) && !(own == i && aw_taken)) begin
        t = head(i);
        ad[i] = t.addr; ln[i] = t.len; mav[i] = roll(p_mv);
      end else begin
        ad[i] = AW'($urandom); ln[i] = 8'($urandom); mav[i] = 1'b0;
      end
      if (in_data && own == i) begin
        wv[i] = roll(p_wv);
        wd[i] = mk_data(cur.id, beats);
        wl[i] = cur.bad ? 1'b0 : lastb;
      end else begin
        wv[i] = 1'($urandom); wd[i] = DW'($urandom); wl[i] = 1'($urandom);
      end
      br[i] = roll(p_br);
    end
    if (br_hold > 0 && in_resp) begin
      br[own] = 1'b0;
      br_hold--;
    end

    m_AWADDR  = {ad[1], ad[0]};
    m_AWLEN   = {ln[1], ln[0]};
    m_AWVALID = mav;
    m_WDATA   = {wd[1], wd[0]};
    m_WVALID  = wv;
    m_WLAST   = wl;
    m_BREADY  = br;
    s_AWREADY = roll(p_ar);
    s_WREADY  = wr_toggle ? toggle_ph : roll(p_wr);
    toggle_ph = ~toggle_ph;
    s_BVALID  = in_resp && roll(p_bv);
    s_BRESP   = 2'($urandom);
    #1;

    e_awrdy = 0; e_wrdy = 0; e_bvalid = 0; e_bresp = 0; e_grant = 0;
    e_aw = 0; e_sw = 0; e_sawv = 0; e_swv = 0; e_sbr = 0; e_err = 0;
    if (own >= 0) e_grant = (own == 0) ? 2'b01 : 2'b10;
    if (in_addr) begin
      e_sawv = mav[own]; e_aw = {ad[own], ln[own]}; e_awrdy[own] = s_AWREADY;
    end
    if (in_data) begin
      e_swv = wv[own]; e_sw = {wd[own], lastb}; e_wrdy[own] = s_WREADY;
      e_err = wv[own] && s_WREADY && (wl[own] != lastb);
    end
    if (in_resp) begin
      e_sbr = br[own]; e_bvalid[own] = s_BVALID;
      e_bresp = (own == 0) ? {2'b00, s_BRESP} : {s_BRESP, 2'b00};
    end
    chk("ctl", {m_AWREADY, m_WREADY, m_BVALID, s_AWVALID, s_WVALID, s_BREADY, grant, wlast_err},
               {e_awrdy, e_wrdy, e_bvalid, e_sawv, e_swv, e_sbr, e_grant, e_err});
    chk("aw", {s_AWADDR, s_AWLEN}, e_aw);
    chk("w", {s_WDATA, s_WLAST}, e_sw);
    chk("b", m_BRESP, e_bresp);

    if (s_WVALID && s_WREADY) begin
      obs_beats++;
      obs_xor ^= s_WDATA;
    end
    if (wlast_err) obs_err++;

    @(posedge ACLK);
    if (own < 0) begin
      if (mav != 2'b00) begin
        own = (mav == 2'b11) ? (1 - last_own) : (mav[1] ? 1 : 0);
        cur = head(own);
        aw_taken = 1'b0;
        gseq.push_back(own);
        obs_beats = 0; obs_xor = 0; obs_err = 0;
        exp_xor = 0;
        for (int b = 0; b <= int'(cur.len); b++) exp_xor ^= mk_data(cur.id, b);
        exp_err = cur.bad ? 1 : 0;
      end
    end else if (!aw_taken) begin
      if (mav[own] && s_AWREADY) begin
        aw_taken = 1'b1;
        beats = 0;
      end
    end else if (in_data) begin
      if (wv[own] && s_WREADY) beats++;
    end else if (s_BVALID && br[own]) begin
      chk("beat_count", obs_beats, int'(cur.len) + 1);
      chk("data_xor", obs_xor, exp_xor);
      chk("wlast_err_count", obs_err, exp_err);
      last_own = own;
      if (own == 0) void'(q0.pop_front());
      else          void'(q1.pop_front());
      own = -1;
      aw_taken = 1'b0;
    end
  endtask

  task automatic run(input string tag, input int budget);
    int c = 0;
    while ((q0.size() > 0 || q1.size() > 0 || own >= 0) && c < budget) begin
      step();
      c++;
    end
    chk({tag, "_timeout"}, (c >= budget) ? 64'd1 : 64'd0, 64'd0);
    if (c >= budget) begin
      q0.delete(); q1.delete();
    end
  endtask

  task automatic chk_seq(input string tag, input int a, input int b);
    chk({tag, "_n"}, gseq.size(), 2);
    chk({tag, "_first"}, (gseq.size() > 0) ? gseq[0] : -1, a);
    chk({tag, "_second"}, (gseq.size() > 1) ? gseq[1] : -1, b);
  endtask

  initial begin
    // Reset state.
    repeat (3) @(posedge ACLK);
    #1;
    chk_zero("reset");
    @(negedge ACLK);
    ARESETn = 1'b1;

    // Simultaneous requests after reset: master 0 first, then master 1; repeat gives same order.
    gseq.delete();
    push(0, 16'h1000, 8'd2, 1'b0);
    push(1, 16'h2000, 8'd1, 1'b0);
    run("pair1", 200);
    chk_seq("pair1", 0, 1);
    gseq.delete();
    push(0, 16'h1100, 8'd0, 1'b0);
    push(1, 16'h2100, 8'd3, 1'b0);
    run("pair2", 200);
    chk_seq("pair2", 0, 1);

    // Master 0 alone, 4-beat burst at 0x0100.
    gseq.delete();
    push(0, 16'h0100, 8'd3, 1'b0);
    run("single", 200);
    chk("single_n", gseq.size(), 1);
    chk("single_owner", (gseq.size() > 0) ? gseq[0] : -1, 0);

    // Master 1 arrives while master 0 is mid-burst; must wait for the B handshake.
    gseq.delete();
    push(0, 16'h0300, 8'd7, 1'b0);
    repeat (4) step();
    push(1, 16'h0400, 8'd2, 1'b0);
    run("late", 200);
    chk_seq("late", 0, 1);

    // WLAST never asserted by the master.
    push(0, 16'h0500, 8'd4, 1'b1);
    run("badlast", 200);

    // Slave WREADY alternating, master BREADY held off for 5 response cycles.
    wr_toggle = 1'b1;
    br_hold = 5;
    push(0, 16'h0600, 8'd6, 1'b0);
    push(1, 16'h0700, 8'd3, 1'b0);
    run("toggle", 300);
    wr_toggle = 1'b0;
    br_hold = 0;

    // Longest burst: 256 beats.
    push(1, 16'h0800, 8'd255, 1'b0);
    run("maxlen", 700);

    // Randomized traffic with random handshake densities.
    for (int k = 0; k < 24; k++) begin
      p_mv = $urandom_range(100, 30); p_ar = $urandom_range(100, 30);
      p_wv = $urandom_range(100, 30); p_wr = $urandom_range(100, 30);
      p_bv = $urandom_range(100, 30); p_br = $urandom_range(100, 30);
      if (roll(70)) push(0, AW'($urandom), 8'($urandom_range(15)), roll(20));
      if (roll(70)) push(1, AW'($urandom), 8'($urandom_range(15)), roll(20));
      if (roll(30)) push(0, AW'($urandom), 8'($urandom_range(15)), roll(20));
      run("rand", 2000);
    end
    p_mv = 100; p_ar = 100; p_wv = 100; p_wr = 100; p_bv = 100; p_br = 100;

    // Reset during beat 2 of an 11-beat burst; last owner before it is master 0.
    push(0, 16'h0900, 8'd0, 1'b0);
    run("prerst", 100);
    push(0, 16'h0A00, 8'd10, 1'b0);
    for (int c = 0; c < 50 && !(own == 0 && aw_taken && beats == 2); c++) step();
    #2;
    ARESETn = 1'b0;
    #1;
    chk_zero("rst_mid");
    own = -1; aw_taken = 1'b0; beats = 0; last_own = 1;
    q0.delete(); q1.delete();
    m_AWVALID = 2'b00;
    m_WVALID  = 2'b00;
    @(negedge ACLK);
    ARESETn = 1'b1;
    gseq.delete();
    push(0, 16'h0B00, 8'd1, 1'b0);
    push(1, 16'h0C00, 8'd1, 1'b0);
    run("postrst", 200);
    chk_seq("postrst", 0, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
